// File: rtl/fifo_rd_arbiter_if.sv
// Read-port bundle between the FIFO read arbiter and its consumers / FIFO.
// No latency of its own; it only groups wires.
// Backpressure is the empty flag plus level requests; r_en and rd_valid are the responses.
interface fifo_rd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic               empty;
    logic               r_en;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rd_valid;
    logic               busy;

    // Arbiter side
    modport master (
        input  req,
        input  empty,
        output r_en,
        output gnt,
        output rd_valid,
        output busy
    );

    // Consumer / FIFO side
    modport slave (
        output req,
        output empty,
        input  r_en,
        input  gnt,
        input  rd_valid,
        input  busy
    );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing the FIFO read port among NUM_REQ read-domain consumers.
// Latency: grant 1 cycle after request, r_en combinational in BURST, rd_valid 1 cycle after r_en.
// Backpressure: empty stalls the burst while holding the grant; optional starve abort via RD_ARB_STARVE_TIMEOUT_EN.
module fifo_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic               r_clk,
    input  logic               r_rst,
    fifo_rd_arbiter_if.master  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    // Elaboration-time parameter range guards
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("fifo_rd_arbiter: NUM_REQ must be 2..8");
    end
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("fifo_rd_arbiter: BURST_LEN must be 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fifo_rd_arbiter: TIMEOUT must be 1..255");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_rd_valid;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_busy;

    logic               w_sel_any;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_in_burst;
    logic               w_req_g;
    logic               w_r_en;
    logic               w_last_beat;
    logic               w_starve_hit;
    logic               w_exit;

    // Round-robin search: first set request starting at last+1, wrapping
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_sel_any = |bus.req;
        w_sel_idx = '0;
        // Walk from farthest to nearest so the nearest hit wins
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = (int'(r_last) + k) % NUM_REQ;
            if (bus.req[v_idx]) begin
                w_sel_idx = IDX_W'(v_idx);
            end
        end
    end

    assign w_in_burst  = (r_state == S_BURST);
    assign w_req_g     = bus.req[r_gidx];
    // Reset forces the read enable low in the cycle it is asserted
    assign w_r_en      = w_in_burst & w_req_g & ~bus.empty & ~r_rst;
    assign w_last_beat = w_r_en & (r_beat_cnt == CNT_W'(BURST_LEN - 1));
    assign w_exit      = w_in_burst & (w_last_beat | ~w_req_g | w_starve_hit);

`ifdef RD_ARB_STARVE_TIMEOUT_EN
    logic [7:0] r_starve_cnt;

    // Count consecutive cycles the granted requester waits on an empty FIFO
    always_ff @(posedge r_clk) begin
        if (r_rst || !w_in_burst || w_exit || !(w_req_g && bus.empty)) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // The TIMEOUT-th stalled cycle ends the burst on the following edge
    assign w_starve_hit = w_in_burst & w_req_g & bus.empty &
                          (r_starve_cnt == 8'(TIMEOUT - 1));
`else
    assign w_starve_hit = 1'b0;
`endif

    // Arbitration / burst FSM with registered grant and busy
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gidx     <= '0;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_any) begin
                        r_state    <= S_BURST;
                        r_gnt      <= NUM_REQ'(1) << w_sel_idx;
                        r_gidx     <= w_sel_idx;
                        r_beat_cnt <= '0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                S_BURST: begin
                    if (w_r_en) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                    if (w_exit) begin
                        r_state <= S_IDLE;
                        r_last  <= r_gidx;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Data-valid strobe follows each read by one cycle, aligned with registered FIFO data
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_rd_valid <= '0;
        end else if (w_r_en) begin
            r_rd_valid <= NUM_REQ'(1) << r_gidx;
        end else begin
            r_rd_valid <= '0;
        end
    end

    assign bus.r_en     = w_r_en;
    assign bus.gnt      = r_gnt;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with NUM_REQ=4, BURST_LEN=4, TIMEOUT=16.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
// Per-cycle expected vectors are hand-derived from the behaviour description.
module tb_fifo_rd_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 16;

    logic r_clk = 1'b0;
    logic r_rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    fifo_rd_arbiter_if #(.NUM_REQ(NUM_REQ)) u_bus ();

    fifo_rd_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .BURST_LEN(BURST_LEN),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .r_clk(r_clk),
        .r_rst(r_rst),
        .bus  (u_bus)
    );

    always #5 r_clk = ~r_clk;

    // Observed {gnt, r_en, rd_valid, busy}
    wire [9:0] obs = {u_bus.gnt, u_bus.r_en, u_bus.rd_valid, u_bus.busy};

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic apply_reset();
        r_rst       = 1'b1;
        u_bus.req   = '0;
        u_bus.empty = 1'b0;
        tick();
        tick();
        r_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        r_rst       = 1'b1;
        u_bus.req   = 4'b1111;
        u_bus.empty = 1'b0;
        tick();
        #1;
        exp = '0;
        n_checks++;
        if (obs !== exp) $display("FAIL reset_active got=%b exp=%b", obs, exp);
        else n_pass++;
        tick();
        r_rst     = 1'b0;
        u_bus.req = '0;
        #1;
        n_checks++;
        if (obs !== exp) $display("FAIL reset_release got=%b exp=%b", obs, exp);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [3:0] eg [0:6] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
        logic       er [0:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] ev [0:6] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        logic [9:0] exp;
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            u_bus.req   = 4'b0001;
            u_bus.empty = 1'b0;
            #1;
            exp = {eg[k], er[k], ev[k], er[k]};
            n_checks++;
            if (obs !== exp) $display("FAIL single k=%0d got=%b exp=%b", k, obs, exp);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g, prev_g;
        logic       r, prev_r;
        logic [9:0] exp;
        prev_g = '0;
        prev_r = 1'b0;
        apply_reset();
        for (int k = 0; k < 22; k++) begin
            u_bus.req   = 4'b1111;
            u_bus.empty = 1'b0;
            #1;
            if (k == 0 || ((k - 1) % 5) == 4) g = 4'h0;
            else g = 4'(1 << (((k - 1) / 5) % 4));
            r   = (g != 4'h0);
            exp = {g, r, (prev_r ? prev_g : 4'h0), r};
            n_checks++;
            if (obs !== exp) $display("FAIL round_robin k=%0d got=%b exp=%b", k, obs, exp);
            else n_pass++;
            prev_g = g;
            prev_r = r;
            tick();
        end
    endtask

    task automatic test_empty_stall();
        logic [3:0] eg [0:11] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4,
                                  4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4};
        logic       er [0:11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] ev [0:11] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0,
                                  4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0};
        logic       eb [0:11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [9:0] exp;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            u_bus.req   = 4'b0100;
            u_bus.empty = (k >= 3 && k <= 7);
            #1;
            exp = {eg[k], er[k], ev[k], eb[k]};
            n_checks++;
            if (obs !== exp) $display("FAIL empty_stall k=%0d got=%b exp=%b", k, obs, exp);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_early_release();
        logic [3:0] rq [0:4] = '{4'b0010, 4'b0010, 4'b0101, 4'b0101, 4'b0101};
        logic [3:0] eg [0:4] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h4};
        logic       er [0:4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] ev [0:4] = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
        logic       eb [0:4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [9:0] exp;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            u_bus.req   = rq[k];
            u_bus.empty = 1'b0;
            #1;
            exp = {eg[k], er[k], ev[k], eb[k]};
            n_checks++;
            if (obs !== exp) $display("FAIL early_release k=%0d got=%b exp=%b", k, obs, exp);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] eg [0:10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0,
                                  4'h2, 4'h2, 4'h2, 4'h0, 4'h1};
        logic       er [0:10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] ev [0:10] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1,
                                  4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
        logic       eb [0:10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [9:0] exp;
        apply_reset();
        for (int k = 0; k < 11; k++) begin
            u_bus.req   = 4'b0011;
            u_bus.empty = 1'b0;
            r_rst       = (k == 8);
            #1;
            exp = {eg[k], er[k], ev[k], eb[k]};
            n_checks++;
            if (obs !== exp) $display("FAIL mid_reset k=%0d got=%b exp=%b", k, obs, exp);
            else n_pass++;
            tick();
        end
        r_rst = 1'b0;
    endtask

    task automatic test_starve();
        logic [9:0] exp;
        apply_reset();
`ifdef RD_ARB_STARVE_TIMEOUT_EN
        for (int k = 0; k < 20; k++) begin
            u_bus.req   = 4'b0011;
            u_bus.empty = 1'b1;
            #1;
            if (k == 0 || k == 17) exp = '0;
            else if (k <= 16)      exp = {4'h1, 1'b0, 4'h0, 1'b1};
            else                   exp = {4'h2, 1'b0, 4'h0, 1'b1};
            n_checks++;
            if (obs !== exp) $display("FAIL starve_timeout k=%0d got=%b exp=%b", k, obs, exp);
            else n_pass++;
            tick();
        end
`else
        for (int k = 0; k < 41; k++) begin
            u_bus.req   = 4'b0011;
            u_bus.empty = 1'b1;
            #1;
            if (k == 0) exp = '0;
            else        exp = {4'h1, 1'b0, 4'h0, 1'b1};
            n_checks++;
            if (obs !== exp) $display("FAIL starve_hold k=%0d got=%b exp=%b", k, obs, exp);
            else n_pass++;
            tick();
        end
`endif
    endtask

    initial begin
        u_bus.req   = '0;
        u_bus.empty = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_empty_stall();
        test_early_release();
        test_mid_reset();
        test_starve();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
